// File: rtl/mst_imp_rd_dma_if.sv
// AXI4-lite read channel bundle (AR + R) between the window read master and memory.
interface mst_imp_rd_dma_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    modport master (
        output arvalid, araddr, arprot, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, arprot, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/mst_imp_rd_dma.sv
// 2-D window read master: credit-limited AR issue, read-data FIFO and tagged pixel stream.
//   state   | meaning
//   S_IDLE  | waiting for a rising edge on IMP_ST
//   S_ISSUE | walking the window row-major, issuing one AR per word
//   S_DRAIN | all ARs issued; waiting for R beats and stream drain
//   S_DONE  | one-cycle completion pulse
module mst_imp_rd_dma #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int CW         = 8,
    parameter int MAX_OUTST  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   PoR_rst_n,
    mst_imp_rd_dma_if.master       mem_axi,
    input  logic [CW-1:0]          IMP_HSIZE,
    input  logic [CW-1:0]          IMP_VSIZE,
    input  logic [AW-1:0]          IMP_SRC_BADDR,
    input  logic [AW-1:0]          IMP_ADR_PITCH,
    input  logic                   IMP_ST,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [DW-1:0]          pix_data,
    output logic                   pix_sol,
    output logic                   pix_eol,
    output logic                   pix_eof,
    output logic                   imp_busy,
    output logic                   imp_done,
    output logic                   imp_err
);
    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0] STRIDE = AW'(DW / 8);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     st_hist_q;
    logic [CW-1:0]  hsize_q, vsize_q, x_q, y_q, ox_q, oy_q;
    logic [AW-1:0]  pitch_q, row_base_q, araddr_q;
    logic [OW-1:0]  outst_q;
    logic [FCW-1:0] fifo_cnt_q;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic           err_q;

    logic trigger, zero_size, credit_ok, ar_hs, r_hs, pop;
    logic x_last, y_last, ox_last, oy_last;

    assign trigger   = (st_hist_q == 2'b01) && (state_q == S_IDLE);
    assign zero_size = (IMP_HSIZE == '0) || (IMP_VSIZE == '0);
    // outstanding + buffered never grows without an AR, so arvalid stays up until accepted
    assign credit_ok = (outst_q < OW'(MAX_OUTST)) &&
                       ((32'(outst_q) + 32'(fifo_cnt_q)) < 32'(FIFO_DEPTH));

    assign mem_axi.arvalid = (state_q == S_ISSUE) && credit_ok;
    assign mem_axi.araddr  = araddr_q;
    assign mem_axi.arprot  = 3'b000;
    assign mem_axi.rready  = 1'b1;

    assign ar_hs = mem_axi.arvalid && mem_axi.arready;
    assign r_hs  = mem_axi.rvalid && (outst_q != '0);
    assign pop   = pix_valid && pix_ready;

    assign x_last  = (x_q == hsize_q - CW'(1));
    assign y_last  = (y_q == vsize_q - CW'(1));
    assign ox_last = (ox_q == hsize_q - CW'(1));
    assign oy_last = (oy_q == vsize_q - CW'(1));

    assign pix_valid = (fifo_cnt_q != '0);
    assign pix_data  = fifo_mem_q[rd_ptr_q];
    assign pix_sol   = pix_valid && (ox_q == '0);
    assign pix_eol   = pix_valid && ox_last;
    assign pix_eof   = pix_eol && oy_last;

    assign imp_busy = (state_q != S_IDLE);
    assign imp_done = (state_q == S_DONE);
    assign imp_err  = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trigger) state_d = zero_size ? S_DONE : S_ISSUE;
            S_ISSUE: if (ar_hs && x_last && y_last) state_d = S_DRAIN;
            // leave on the edge that hands off the final word
            S_DRAIN: if ((outst_q == '0) &&
                         ((fifo_cnt_q == '0) || ((fifo_cnt_q == FCW'(1)) && pop)))
                         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge PoR_rst_n) begin
        if (!PoR_rst_n) begin
            state_q   <= S_IDLE;
            st_hist_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            st_hist_q <= {st_hist_q[0], IMP_ST};
        end
    end

    always_ff @(posedge clk or negedge PoR_rst_n) begin
        if (!PoR_rst_n) begin
            hsize_q    <= '0;
            vsize_q    <= '0;
            pitch_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            araddr_q   <= '0;
        end else if (trigger) begin
            hsize_q    <= IMP_HSIZE;
            vsize_q    <= IMP_VSIZE;
            pitch_q    <= IMP_ADR_PITCH;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= IMP_SRC_BADDR;
            araddr_q   <= IMP_SRC_BADDR;
        end else if (ar_hs) begin
            if (x_last) begin
                x_q        <= '0;
                y_q        <= y_q + CW'(1);
                row_base_q <= row_base_q + pitch_q;
                araddr_q   <= row_base_q + pitch_q;
            end else begin
                x_q      <= x_q + CW'(1);
                araddr_q <= araddr_q + STRIDE;
            end
        end
    end

    always_ff @(posedge clk or negedge PoR_rst_n) begin
        if (!PoR_rst_n) begin
            ox_q <= '0;
            oy_q <= '0;
        end else if (trigger) begin
            ox_q <= '0;
            oy_q <= '0;
        end else if (pop) begin
            if (ox_last) begin
                ox_q <= '0;
                oy_q <= oy_q + CW'(1);
            end else begin
                ox_q <= ox_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge PoR_rst_n) begin
        if (!PoR_rst_n) begin
            outst_q <= '0;
        end else begin
            case ({ar_hs, r_hs})
                2'b10:   outst_q <= outst_q + OW'(1);
                2'b01:   outst_q <= outst_q - OW'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge PoR_rst_n) begin
        if (!PoR_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (r_hs) begin
                fifo_mem_q[wr_ptr_q] <= mem_axi.rdata;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({r_hs, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + FCW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - FCW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge PoR_rst_n) begin
        if (!PoR_rst_n) begin
            err_q <= 1'b0;
        end else if (trigger) begin
            err_q <= 1'b0;
        end else if (r_hs && (mem_axi.rresp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mst_imp_rd_dma.sv
// Bench for mst_imp_rd_dma: memory responder, window reference model, directed and random tasks.
module tb_mst_imp_rd_dma;
    localparam int AW = 32, DW = 32, CW = 8, MO = 4, FD = 8;

    logic clk = 1'b0;
    logic PoR_rst_n = 1'b0;
    always #5 clk = ~clk;

    mst_imp_rd_dma_if #(.AW(AW), .DW(DW)) mem_axi ();

    logic [CW-1:0] IMP_HSIZE = '0, IMP_VSIZE = '0;
    logic [AW-1:0] IMP_SRC_BADDR = '0, IMP_ADR_PITCH = '0;
    logic          IMP_ST = 1'b0;
    logic          pix_valid, pix_ready, pix_sol, pix_eol, pix_eof;
    logic [DW-1:0] pix_data;
    logic          imp_busy, imp_done, imp_err;

    mst_imp_rd_dma #(.AW(AW), .DW(DW), .CW(CW), .MAX_OUTST(MO), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .PoR_rst_n(PoR_rst_n), .mem_axi(mem_axi),
        .IMP_HSIZE(IMP_HSIZE), .IMP_VSIZE(IMP_VSIZE),
        .IMP_SRC_BADDR(IMP_SRC_BADDR), .IMP_ADR_PITCH(IMP_ADR_PITCH), .IMP_ST(IMP_ST),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .imp_busy(imp_busy), .imp_done(imp_done), .imp_err(imp_err)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        sol, eol, eof;
    } pix_t;

    int n_asrt = 0, n_fail = 0;

    // reference model state
    logic [31:0] exp_addr[$];
    pix_t        exp_pix[$];
    logic [31:0] pending[$];
    logic [31:0] salt;
    int          exp_n, exp_err;
    int          ar_cnt, pix_cnt, r_beat, done_cnt, max_outst, max_credit, first_ar, last_ar;
    int          cyc = 0;
    int          ar_mode = 1, r_mode = 1, pix_mode = 1, err_beat = -1;

    // responder-local state
    logic        eof_prev = 1'b0, ar_stall_prev = 1'b0, pix_stall_prev = 1'b0;
    logic [31:0] ar_prev_addr, pix_prev_data, ra;
    pix_t        rp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic mv(input int m);
        if (m == 2) return 1'($urandom_range(0, 1));
        return (m == 1);
    endfunction

    task automatic clear_model();
        exp_addr.delete(); exp_pix.delete(); pending.delete();
        ar_cnt = 0; pix_cnt = 0; r_beat = 0; done_cnt = 0;
        max_outst = 0; max_credit = 0; first_ar = -1; last_ar = -1;
    endtask

    task automatic build_model(input int h, input int v, input logic [31:0] base,
                               input logic [31:0] pitch, input int eb);
        logic [31:0] a;
        pix_t p;
        clear_model();
        salt = $urandom;
        for (int y = 0; y < v; y++)
            for (int x = 0; x < h; x++) begin
                a = base + 32'(y) * pitch + 32'(x * 4);
                exp_addr.push_back(a);
                p.d = a ^ salt;
                p.sol = (x == 0);
                p.eol = (x == h - 1);
                p.eof = (x == h - 1) && (y == v - 1);
                exp_pix.push_back(p);
            end
        exp_n    = h * v;
        err_beat = eb;
        exp_err  = (eb >= 0 && eb < h * v) ? 1 : 0;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_arvalid"}, mem_axi.arvalid, 0);
        chk({pfx, "_araddr"}, mem_axi.araddr, 0);
        chk({pfx, "_arprot"}, mem_axi.arprot, 0);
        chk({pfx, "_rready"}, mem_axi.rready, 1);
        chk({pfx, "_pix_valid"}, pix_valid, 0);
        chk({pfx, "_pix_data"}, pix_data, 0);
        chk({pfx, "_tags"}, {pix_sol, pix_eol, pix_eof}, 0);
        chk({pfx, "_busy"}, imp_busy, 0);
        chk({pfx, "_done"}, imp_done, 0);
        chk({pfx, "_err"}, imp_err, 0);
    endtask

    // called at posedge+1 with IMP_ST low for at least one prior edge
    task automatic start(input int h, input int v, input logic [31:0] base, input logic [31:0] pitch);
        IMP_HSIZE = CW'(h); IMP_VSIZE = CW'(v);
        IMP_SRC_BADDR = base; IMP_ADR_PITCH = pitch;
        IMP_ST = 1'b1;
        @(posedge clk); #1;
        chk("start_busy_edgeN", imp_busy, 0);
        @(posedge clk); #1;
        chk("start_busy_edgeN1", imp_busy, 1);
        chk("start_arvalid", mem_axi.arvalid, (h != 0 && v != 0));
        chk("start_done_zero", imp_done, (h == 0 || v == 0));
        chk("start_err_cleared", imp_err, 0);
        IMP_ST = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_timeout", (done_cnt != 0), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_single_pulse", done_cnt, 1);
        chk("idle_after_done", imp_busy, 0);
    endtask

    task automatic final_checks(input string tag);
        chk({tag, "_ar_count"}, ar_cnt, exp_n);
        chk({tag, "_pix_count"}, pix_cnt, exp_n);
        chk({tag, "_err"}, imp_err, exp_err);
        chk({tag, "_outst_bound"}, (max_outst <= MO), 1);
        chk({tag, "_credit_bound"}, (max_credit <= FD), 1);
    endtask

    task automatic run_task(input string tag, input int h, input int v, input logic [31:0] base,
                            input logic [31:0] pitch, input int eb);
        build_model(h, v, base, pitch, eb);
        start(h, v, base, pitch);
        wait_done(3000);
        final_checks(tag);
    endtask

    // memory responder and stream monitor; inputs change on the falling edge
    initial begin
        mem_axi.arready = 1'b0; mem_axi.rvalid = 1'b0;
        mem_axi.rdata = '0; mem_axi.rresp = 2'b00; pix_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!PoR_rst_n) begin
                eof_prev = 1'b0; ar_stall_prev = 1'b0; pix_stall_prev = 1'b0;
                mem_axi.arready = 1'b0; mem_axi.rvalid = 1'b0; pix_ready = 1'b0;
            end else begin
                if (eof_prev) chk("done_after_eof", imp_done, 1);
                eof_prev = 1'b0;
                if (imp_done) done_cnt++;
                if (ar_stall_prev) begin
                    chk("ar_hold_valid", mem_axi.arvalid, 1);
                    chk("ar_hold_addr", mem_axi.araddr, ar_prev_addr);
                end
                if (pix_stall_prev) begin
                    chk("pix_hold_valid", pix_valid, 1);
                    chk("pix_hold_data", pix_data, pix_prev_data);
                end
                mem_axi.arready = mv(ar_mode);
                if (pending.size() > 0 && mv(r_mode)) begin
                    ra = pending.pop_front();
                    mem_axi.rvalid = 1'b1;
                    mem_axi.rdata  = ra ^ salt;
                    mem_axi.rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
                    r_beat++;
                end else begin
                    mem_axi.rvalid = 1'b0;
                    mem_axi.rdata  = $urandom;
                    mem_axi.rresp  = 2'b00;
                end
                ar_stall_prev = mem_axi.arvalid && !mem_axi.arready;
                ar_prev_addr  = mem_axi.araddr;
                if (mem_axi.arvalid && mem_axi.arready) begin
                    if (ar_cnt < exp_addr.size())
                        chk($sformatf("ar_addr[%0d]", ar_cnt), mem_axi.araddr, exp_addr[ar_cnt]);
                    else
                        chk("ar_extra", ar_cnt, exp_addr.size());
                    pending.push_back(mem_axi.araddr);
                    ar_cnt++;
                    if (first_ar < 0) first_ar = cyc;
                    last_ar = cyc;
                end
                if (pending.size() > max_outst) max_outst = pending.size();
                pix_ready = mv(pix_mode);
                pix_stall_prev = pix_valid && !pix_ready;
                pix_prev_data  = pix_data;
                if (pix_valid && pix_ready) begin
                    if (exp_pix.size() > 0) begin
                        rp = exp_pix.pop_front();
                        chk($sformatf("pix_data[%0d]", pix_cnt), pix_data, rp.d);
                        chk($sformatf("pix_tags[%0d]", pix_cnt), {pix_sol, pix_eol, pix_eof},
                            {rp.sol, rp.eol, rp.eof});
                        eof_prev = rp.eof;
                    end else begin
                        chk("pix_extra", pix_cnt, exp_n);
                    end
                    pix_cnt++;
                end
                if (ar_cnt - pix_cnt > max_credit) max_credit = ar_cnt - pix_cnt;
            end
        end
    end

    initial begin
        int h, v, eb;
        clear_model();
        salt = '0; exp_n = 0; exp_err = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("rst_held");
        #2 PoR_rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("rst_released");

        // nominal 4x3 window, everything ready: back-to-back ARs
        ar_mode = 1; r_mode = 1; pix_mode = 1;
        run_task("nominal", 4, 3, 32'h1000, 32'h40, -1);
        chk("b2b_ar_span", last_ar - first_ar, 11);

        // R stalled: outstanding limit stops AR issue at MAX_OUTST
        build_model(4, 3, 32'h2000, 32'h80, -1);
        r_mode = 0;
        start(4, 3, 32'h2000, 32'h80);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_r_ar_count", ar_cnt, MO);
        chk("stall_r_arvalid", mem_axi.arvalid, 0);
        r_mode = 1;
        wait_done(3000);
        final_checks("stall_r");

        // stream stalled: credit stops AR issue at FIFO_DEPTH
        build_model(4, 4, 32'h4000, 32'h100, -1);
        pix_mode = 0;
        start(4, 4, 32'h4000, 32'h100);
        repeat (30) @(posedge clk);
        #1;
        chk("stall_pix_ar_count", ar_cnt, FD);
        chk("stall_pix_none_out", pix_cnt, 0);
        chk("stall_pix_arvalid", mem_axi.arvalid, 0);
        pix_mode = 1;
        wait_done(3000);
        final_checks("stall_pix");

        // address wrap-around at 2^32
        run_task("wrap", 4, 1, 32'hFFFF_FFF8, 32'h40, -1);

        // empty windows
        run_task("zero_h", 0, 3, 32'h5000, 32'h40, -1);
        run_task("zero_v", 5, 0, 32'h5000, 32'h40, -1);

        // second start edge and input changes while busy are ignored
        build_model(3, 3, 32'h3000, 32'h20, -1);
        ar_mode = 1; r_mode = 2; pix_mode = 2;
        start(3, 3, 32'h3000, 32'h20);
        repeat (3) @(posedge clk);
        #1;
        IMP_HSIZE = 8'd7; IMP_SRC_BADDR = 32'h0;
        IMP_ST = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        IMP_ST = 1'b0;
        wait_done(3000);
        final_checks("retrigger");

        // error response on word 2: flagged, all words still delivered
        ar_mode = 1; r_mode = 1; pix_mode = 1;
        run_task("rresp_err", 4, 2, 32'h6000, 32'h40, 1);

        // reset during ISSUE aborts, then a clean task
        build_model(4, 3, 32'h7000, 32'h100, 0);
        start(4, 3, 32'h7000, 32'h100);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_err", imp_err, 1);
        chk("pre_reset_busy", imp_busy, 1);
        #2 PoR_rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        clear_model();
        err_beat = -1;
        repeat (2) @(posedge clk);
        #3 PoR_rst_n = 1'b1;
        @(posedge clk); #1;
        run_task("post_reset", 3, 2, 32'h8000, 32'h40, -1);

        // random windows, handshakes and error beats
        for (int t = 0; t < 6; t++) begin
            h = $urandom_range(1, 6);
            v = $urandom_range(1, 4);
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, h * v - 1)) : -1;
            ar_mode  = $urandom_range(1, 2);
            r_mode   = $urandom_range(1, 2);
            pix_mode = $urandom_range(1, 2);
            run_task($sformatf("rand%0d", t), h, v, $urandom & 32'hFFFF_FFFC,
                     32'($urandom_range(0, 255)) * 32'd4, eb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
